// File: rtl/macc_host_port.sv
// Host-side initiator for the matrix accelerator memory ports: turns LOAD/UNLOAD
// commands plus valid/ready streams into per-matrix write/read enables and data.
module macc_host_port #(
  parameter int WORDS = 4096,
  parameter int DW    = 32,
  localparam int CW   = $clog2(WORDS + 1)
) (
  input  logic          CLK,
  input  logic          RST_L,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [1:0]    cmd_sel,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic [2:0]    wen,
  output logic [2:0]    ren,
  output logic [DW-1:0] mat_wdata,
  input  logic [DW-1:0] mat_a_rdata,
  input  logic [DW-1:0] mat_b_rdata,
  input  logic [DW-1:0] mat_c_rdata,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, LOAD, UNLOAD} state_t;

  state_t          state, state_nxt;
  logic [1:0]      sel_q;
  logic [2:0]      sel_oh;
  logic [CW-1:0]   beat_cnt, iss_cnt, push_cnt;
  logic            inflight;
  logic            done_nxt;
  logic            cmd_fire, s_fire, m_fire, ren_ok;
  logic [DW-1:0]   rdata_mux;

  logic [DW-1:0]   fifo_data [4];
  logic [3:0]      fifo_last;
  logic [1:0]      wr_ptr, rd_ptr;
  logic [2:0]      fifo_cnt;

  assign sel_oh    = 3'b001 << sel_q;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign s_ready   = (state == LOAD);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign s_fire    = s_valid & s_ready;
  assign m_fire    = m_valid & m_ready;

  // Read issue depends only on registered state so m_ready never reaches ren.
  // Slots in use = FIFO entries plus the read whose data arrives this cycle.
  assign ren_ok = (state == UNLOAD) && (iss_cnt < CW'(WORDS)) &&
                  (({1'b0, fifo_cnt} + {3'b000, inflight}) < 4'd4);
  assign ren    = ren_ok ? sel_oh : 3'b000;

  always_comb begin
    case (sel_q)
      2'd2:    rdata_mux = mat_a_rdata;
      2'd1:    rdata_mux = mat_b_rdata;
      default: rdata_mux = mat_c_rdata;
    endcase
  end

  assign m_valid = (fifo_cnt != 3'd0);
  assign m_data  = m_valid ? fifo_data[rd_ptr] : '0;
  assign m_last  = m_valid & fifo_last[rd_ptr];

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_sel == 2'd3) done_nxt  = 1'b1;
          else                 state_nxt = cmd_op ? UNLOAD : LOAD;
        end
      end
      LOAD: begin
        if (s_fire && beat_cnt == CW'(WORDS - 1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      UNLOAD: begin
        if (m_fire && m_last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state     <= IDLE;
      done      <= 1'b0;
      sel_q     <= 2'd0;
      beat_cnt  <= '0;
      iss_cnt   <= '0;
      push_cnt  <= '0;
      inflight  <= 1'b0;
      wen       <= 3'b000;
      mat_wdata <= '0;
    end else begin
      state    <= state_nxt;
      done     <= done_nxt;
      inflight <= ren_ok;
      wen      <= s_fire ? sel_oh : 3'b000;
      if (s_fire) mat_wdata <= s_data;
      if (cmd_fire) begin
        sel_q    <= cmd_sel;
        beat_cnt <= '0;
        iss_cnt  <= '0;
        push_cnt <= '0;
      end else begin
        if (s_fire)   beat_cnt <= beat_cnt + 1'b1;
        if (ren_ok)   iss_cnt  <= iss_cnt + 1'b1;
        if (inflight) push_cnt <= push_cnt + 1'b1;
      end
    end
  end

  // Output FIFO: one push per returned read, one pop per m handshake.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      for (int i = 0; i < 4; i++) fifo_data[i] <= '0;
      fifo_last <= 4'b0000;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      fifo_cnt  <= 3'd0;
    end else begin
      if (inflight) begin
        fifo_data[wr_ptr] <= rdata_mux;
        fifo_last[wr_ptr] <= (push_cnt == CW'(WORDS - 1));
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (m_fire) rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + {2'b00, inflight} - {2'b00, m_fire};
    end
  end

endmodule

// File: tb/tb_macc_host_port.sv
// Randomized bench for macc_host_port: behavioural accelerator memory plus a
// word-order reference of every matrix, checked at the stream/enable level.
module tb_macc_host_port;
  localparam int WORDS = 4096;
  localparam int DW    = 32;
  localparam int LIM   = WORDS * 4 + 50;

  logic          CLK = 1'b0;
  logic          RST_L = 1'b0;
  logic          cmd_valid = 1'b0, cmd_op = 1'b0;
  logic [1:0]    cmd_sel = 2'd0;
  logic          cmd_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0, s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last, m_ready = 1'b0;
  logic [2:0]    wen, ren;
  logic [DW-1:0] mat_wdata, mat_a_rdata, mat_b_rdata, mat_c_rdata;
  logic          busy, done;

  int n_cmp = 0, n_err = 0;

  logic [DW-1:0] ref_mem [3][WORDS];

  macc_host_port #(.WORDS(WORDS), .DW(DW)) dut (
    .CLK(CLK), .RST_L(RST_L),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sel(cmd_sel),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .wen(wen), .ren(ren), .mat_wdata(mat_wdata),
    .mat_a_rdata(mat_a_rdata), .mat_b_rdata(mat_b_rdata), .mat_c_rdata(mat_c_rdata),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  // Accelerator memories: address counters advance on every enable, read data one cycle later.
  logic [DW-1:0] acc_mem [3][WORDS];
  logic [DW-1:0] acc_rd [3];
  int            waddr [3];
  int            raddr [3];

  always @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      for (int i = 0; i < 3; i++) begin
        waddr[i]  <= 0;
        raddr[i]  <= 0;
        acc_rd[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (wen[i]) begin
          acc_mem[i][waddr[i]] <= mat_wdata;
          waddr[i] <= (waddr[i] + 1) % WORDS;
        end
        if (ren[i]) begin
          acc_rd[i] <= acc_mem[i][raddr[i]];
          raddr[i]  <= (raddr[i] + 1) % WORDS;
        end
      end
    end
  end

  assign mat_a_rdata = acc_rd[2];
  assign mat_b_rdata = acc_rd[1];
  assign mat_c_rdata = acc_rd[0];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_cmd(input logic op, input logic [1:0] sel);
    @(negedge CLK);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sel   = sel;
    chk("cmd_ready_on_offer", cmd_ready, 1);
  endtask

  task automatic do_load(input logic [1:0] sel, input bit rnd, input bit chain);
    logic [DW-1:0] exp_q [$];
    logic [2:0]    oh;
    int            sent, wcnt, errs, rd_err, dcnt, cr_err, sr_err;
    bit            fin;
    oh = 3'b001 << sel;
    sent = 0; wcnt = 0; errs = 0; rd_err = 0; dcnt = 0; cr_err = 0; sr_err = 0; fin = 0;
    start_cmd(1'b0, sel);
    for (int c = 1; c < LIM && !fin; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        if (chain) begin cmd_op = 1'b1; cmd_sel = sel; end
        else cmd_valid = 1'b0;
        chk("load_busy", busy, 1);
      end
      if (wen != 3'b000) begin
        if (wen !== oh || exp_q.size() == 0 || mat_wdata !== exp_q[0]) errs++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        wcnt++;
      end
      if (ren != 3'b000) rd_err++;
      if (done) dcnt++;
      if (s_ready !== (sent < WORDS)) sr_err++;
      if (chain && wcnt < WORDS && cmd_ready) cr_err++;
      if (wcnt == WORDS) begin
        fin = 1;
        chk("load_done_with_last_wen", done, 1);
        chk("load_cmd_ready_at_end", cmd_ready, 1);
        s_valid = 1'b1;
        s_data  = 32'hdead_beef;
      end else begin
        s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        s_data  = rnd ? DW'($urandom) : DW'(sent);
        if (s_valid && sent < WORDS) begin
          exp_q.push_back(s_data);
          ref_mem[sel][sent] = s_data;
          sent++;
        end
      end
    end
    chk("load_wen_count", wcnt, WORDS);
    chk("load_data_order", errs, 0);
    chk("load_no_ren", rd_err, 0);
    chk("load_done_count", dcnt, 1);
    chk("load_s_ready", sr_err, 0);
    if (chain) chk("load_cmd_ready_held_low", cr_err, 0);
    else begin
      @(negedge CLK);
      s_valid = 1'b0;
      chk("load_extra_beat_rejected", wen, 0);
      chk("load_idle_busy", busy, 0);
    end
  endtask

  task automatic do_unload(input logic [1:0] sel, input bit rnd, input bit timing, input bit chained);
    logic [2:0]    oh;
    int            idx, rcnt, first_ren, first_mv, last_c, done_c, dcnt;
    int            errs, stall_err, out_err, ovl, oh_err;
    logic          pv, pr, pl;
    logic [DW-1:0] pd;
    oh = 3'b001 << sel;
    idx = 0; rcnt = 0; first_ren = -1; first_mv = -1; last_c = -1; done_c = -1; dcnt = 0;
    errs = 0; stall_err = 0; out_err = 0; ovl = 0; oh_err = 0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    if (!chained) start_cmd(1'b1, sel);
    for (int c = 1; c < LIM && dcnt == 0; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        cmd_valid = 1'b0;
        s_valid   = 1'b0;
        chk("unload_busy", busy, 1);
      end
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wen != 3'b000) ovl++;
      if (ren != 3'b000) begin
        if (ren !== oh) oh_err++;
        if (first_ren < 0) first_ren = c;
        rcnt++;
      end
      if (rcnt - idx > 4) out_err++;
      if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) stall_err++;
      if (m_valid && first_mv < 0) first_mv = c;
      if (m_valid && m_ready) begin
        if (idx >= WORDS || m_data !== ref_mem[sel][idx] || m_last !== (idx == WORDS - 1)) errs++;
        if (idx == WORDS - 1) last_c = c;
        idx++;
      end
      if (done) begin dcnt++; done_c = c; end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
    end
    m_ready = 1'b0;
    chk("unload_words", idx, WORDS);
    chk("unload_ren_count", rcnt, WORDS);
    chk("unload_ren_onehot", oh_err, 0);
    chk("unload_data_order", errs, 0);
    chk("unload_stall_stable", stall_err, 0);
    chk("unload_outstanding_le4", out_err, 0);
    chk("unload_no_wen", ovl, 0);
    chk("unload_done_seen", dcnt, 1);
    chk("unload_done_after_last", done_c, last_c + 1);
    chk("unload_idle_at_done", busy, 0);
    if (timing) begin
      chk("unload_first_ren_cycle", first_ren, 1);
      chk("unload_first_mvalid_cycle", first_mv, 3);
      chk("unload_last_beat_cycle", last_c, WORDS + 2);
      chk("unload_done_cycle", done_c, WORDS + 3);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, {wen, ren, s_ready, m_valid, m_last, busy, done}, 0);
    chk({tag, "_wdata"}, mat_wdata, 0);
    chk({tag, "_mdata"}, m_data, 0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk_reset_outs("reset");
    RST_L = 1'b1;
    @(negedge CLK);
    chk("reset_cmd_ready", cmd_ready, 1);

    do_load(2'd2, 1'b0, 1'b0);
    do_unload(2'd2, 1'b0, 1'b1, 1'b0);

    do_load(2'd1, 1'b1, 1'b0);
    do_unload(2'd1, 1'b1, 1'b0, 1'b0);

    do_load(2'd0, 1'b1, 1'b1);
    do_unload(2'd0, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of a LOAD of A
    start_cmd(1'b0, 2'd2);
    for (int c = 1; c <= 100; c++) begin
      @(negedge CLK);
      if (c == 1) cmd_valid = 1'b0;
      s_valid = 1'b1;
      s_data  = $urandom;
    end
    @(posedge CLK);
    #2;
    chk("mid_load_busy", busy, 1);
    RST_L = 1'b0;
    #1;
    chk_reset_outs("async_reset");
    @(negedge CLK);
    s_valid = 1'b0;
    repeat (2) @(negedge CLK);
    RST_L = 1'b1;
    @(negedge CLK);
    chk("post_reset_cmd_ready", cmd_ready, 1);
    chk("post_reset_busy", busy, 0);
    do_load(2'd2, 1'b1, 1'b0);
    do_unload(2'd2, 1'b0, 1'b1, 1'b0);

    // Invalid matrix select
    start_cmd(1'b0, 2'd3);
    @(negedge CLK);
    cmd_valid = 1'b0;
    chk("sel3_done", done, 1);
    chk("sel3_busy", busy, 0);
    chk("sel3_no_enables", {wen, ren}, 0);
    @(negedge CLK);
    chk("sel3_done_one_cycle", done, 0);
    chk("sel3_cmd_ready", cmd_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
